sequencer: RTL and testbench

SEQUENCER -- requirements
Module: sequencer

---
 rtl/sequencer.sv | 78 +++++++
 tb/tb_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sequencer.sv
// Microcode step sequencer: latches opcodes from the data bus, walks decoder steps,
// evaluates branch conditions and counts retired opcodes, with a sticky overflow trap.
module sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DATA_W-1:0] db_in,
  input  logic              done,
  input  logic              is_cond,
  input  logic [2:0]        next_cond,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic [DATA_W-1:0] opcode,
  output logic [2:0]        step,
  output logic              boot,
  output logic              cond_met,
  output logic [15:0]       retire_count,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    EXEC  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t state;

  // Condition code lives in opcode[4:3]: NZ, Z, NC, C.
  function automatic logic cond_eval(input logic [1:0] cc, input logic z, input logic c);
    case (cc)
      2'd0:    return ~z;
      2'd1:    return z;
      2'd2:    return ~c;
      default: return c;
    endcase
  endfunction

  assign cond_met = cond_eval(opcode[4:3], flag_z, flag_c);
  assign boot     = (state == BOOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      opcode       <= '0;
      step         <= '0;
      retire_count <= '0;
      seq_err      <= 1'b0;
    end else if (!stall) begin
      case (state)
        BOOT: begin
          opcode <= db_in;
          step   <= '0;
          state  <= EXEC;
        end
        EXEC: begin
          if (done) begin
            opcode       <= db_in;
            step         <= '0;
            retire_count <= retire_count + 16'd1;
          end else if (is_cond && !cond_met) begin
            // A failed branch jumps anywhere, even from step 7, without trapping.
            step <= next_cond;
          end else if (step == 3'd7) begin
            state   <= ERROR;
            seq_err <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: expected register values are queued as each
// stimulus cycle is driven and compared once the DUT has clocked it.
module tb_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [7:0]  db_in;
  logic        done;
  logic        is_cond;
  logic [2:0]  next_cond;
  logic        flag_z;
  logic        flag_c;
  logic [7:0]  opcode;
  logic [2:0]  step;
  logic        boot;
  logic        cond_met;
  logic [15:0] retire_count;
  logic        seq_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [7:0]  op;
    logic [2:0]  st;
    logic        bt;
    logic [15:0] rc;
    logic        er;
  } exp_t;

  exp_t exp_q[$];

  sequencer #(.DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .db_in(db_in),
    .done(done),
    .is_cond(is_cond),
    .next_cond(next_cond),
    .flag_z(flag_z),
    .flag_c(flag_c),
    .opcode(opcode),
    .step(step),
    .boot(boot),
    .cond_met(cond_met),
    .retire_count(retire_count),
    .seq_err(seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic d, input logic ic,
                       input logic [2:0] nc, input logic [7:0] db);
    rst = r; stall = s; done = d; is_cond = ic; next_cond = nc; db_in = db;
  endtask

  task automatic cyc(input string tag, input logic [7:0] op, input logic [2:0] st,
                     input logic bt, input logic [15:0] rc, input logic er);
    exp_t e;
    e.tag = tag; e.op = op; e.st = st; e.bt = bt; e.rc = rc; e.er = er;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".opcode"}, {8'h00, opcode}, {8'h00, e.op});
    chk({e.tag, ".step"}, {13'h0, step}, {13'h0, e.st});
    chk({e.tag, ".boot"}, {15'h0, boot}, {15'h0, e.bt});
    chk({e.tag, ".retire"}, retire_count, e.rc);
    chk({e.tag, ".seq_err"}, {15'h0, seq_err}, {15'h0, e.er});
  endtask

  task automatic chk_cm(input string tag, input logic exp);
    #1;
    chk(tag, {15'h0, cond_met}, {15'h0, exp});
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    flag_z = 1'b0;
    flag_c = 1'b0;
    @(posedge clk);
    #1;

    // Reset and boot, including a stalled boot cycle
    cyc("reset", 8'h00, 3'd0, 1'b1, 16'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h41);
    cyc("boot_stall", 8'h00, 3'd0, 1'b1, 16'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h41);
    cyc("boot", 8'h41, 3'd0, 1'b0, 16'd0, 1'b0);

    // Multi-step opcode
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01);
    cyc("load01", 8'h01, 3'd0, 1'b0, 16'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("ms1", 8'h01, 3'd1, 1'b0, 16'd1, 1'b0);
    cyc("ms2", 8'h01, 3'd2, 1'b0, 16'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h3E);
    cyc("ms_done", 8'h3E, 3'd0, 1'b0, 16'd2, 1'b0);

    // Conditional step, NZ failing then passing
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h20);
    cyc("load20", 8'h20, 3'd0, 1'b0, 16'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("c_s1", 8'h20, 3'd1, 1'b0, 16'd3, 1'b0);
    flag_z = 1'b1;
    chk_cm("cm_nz_z1", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00);
    cyc("c_fail", 8'h20, 3'd3, 1'b0, 16'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h20);
    cyc("reload20", 8'h20, 3'd0, 1'b0, 16'd4, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("c2_s1", 8'h20, 3'd1, 1'b0, 16'd4, 1'b0);
    flag_z = 1'b0;
    chk_cm("cm_nz_z0", 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00);
    cyc("c_pass", 8'h20, 3'd2, 1'b0, 16'd4, 1'b0);

    // Remaining condition codes: C, Z, NC
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h18);
    cyc("load18", 8'h18, 3'd0, 1'b0, 16'd5, 1'b0);
    flag_c = 1'b1;
    chk_cm("cm_c_c1", 1'b1);
    flag_c = 1'b0;
    chk_cm("cm_c_c0", 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h08);
    cyc("load08", 8'h08, 3'd0, 1'b0, 16'd6, 1'b0);
    flag_z = 1'b1;
    chk_cm("cm_z_z1", 1'b1);
    flag_z = 1'b0;
    chk_cm("cm_z_z0", 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10);
    cyc("load10", 8'h10, 3'd0, 1'b0, 16'd7, 1'b0);
    chk_cm("cm_nc_c0", 1'b1);
    flag_c = 1'b1;
    chk_cm("cm_nc_c1", 1'b0);

    // Failed branch from step 7 reloads next_cond instead of trapping
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 1; i <= 7; i++) cyc("walk7", 8'h10, 3'(i), 1'b0, 16'd7, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00);
    cyc("s7_cond", 8'h10, 3'd5, 1'b0, 16'd7, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("s7_after", 8'h10, 3'd6, 1'b0, 16'd7, 1'b0);

    // Stall holds everything, then done applies exactly once
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h55);
    cyc("load55", 8'h55, 3'd0, 1'b0, 16'd8, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("st_s1", 8'h55, 3'd1, 1'b0, 16'd8, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h66);
    for (int i = 0; i < 4; i++) cyc("stall", 8'h55, 3'd1, 1'b0, 16'd8, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h66);
    cyc("unstall", 8'h66, 3'd0, 1'b0, 16'd9, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("post_stall", 8'h66, 3'd1, 1'b0, 16'd9, 1'b0);

    // Step overflow trap, ERROR ignores done, reset clears it
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h77);
    cyc("load77", 8'h77, 3'd0, 1'b0, 16'd10, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 1; i <= 7; i++) cyc("ovf_walk", 8'h77, 3'(i), 1'b0, 16'd10, 1'b0);
    cyc("ovf", 8'h77, 3'd7, 1'b0, 16'd10, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'hAA);
    cyc("err_hold", 8'h77, 3'd7, 1'b0, 16'd10, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'hAA);
    cyc("err_rst", 8'h00, 3'd0, 1'b1, 16'd0, 1'b0);

    // Retire counter wrap with done and is_cond together
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01);
    cyc("boot2", 8'h01, 3'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01);
    repeat (65535) @(posedge clk);
    #1;
    chk("rc_ffff", retire_count, 16'hFFFF);
    flag_z = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'h02);
    cyc("wrap", 8'h02, 3'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("wrap_s1", 8'h02, 3'd1, 1'b0, 16'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 8'h99);
    cyc("rst_prio", 8'h00, 3'd0, 1'b1, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
